vram_slot_arbiter: RTL and testbench
====================================

# vram_slot_arbiter

Shares the single SDRAM memory controller between the VDP and one auxiliary requester (blitter/DMA/CPU direct VRAM access) by scheduling commands against the VDP's slot phase. The VDP keeps absolute priority in its access slots. Refresh slots are lent to the auxiliary requester under a bounded refresh-debt policy. The block sits between the VDP (PRAM side) and MEM_CONTROLLER in the VDP clock domain.

## Interface
- READ_LAT, 2: clk cycles after an aux read command deasserts until mem_dout16 is valid.
- MAX_DEBT, 8: max refresh slots that may be lent to aux before a refresh is forced (1..15).
- clk  in  1  VDP clock (same as MEM_CONTROLLER command domain).
- reset_n  in  1  reset, asynchronous, active-low.
- vdp_dl_clk, vdp_dh_clk  in  1 each  VDP slot phase bits.
- vdp_we_n  in  1  VDP write enable, active low.
- vdp_addr  in  19  VDP VRAM address.
- vdp_din8  in  8  VDP write data.
- aux_req  in  1  aux request, level, held until aux_ack.
- aux_we  in  1  1 = write, 0 = read; stable while aux_req.
- aux_addr  in  23  aux address; stable while aux_req.
- aux_din8  in  8  aux write data; stable while aux_req.
- aux_ack  out  1  one-clk grant pulse.
- aux_rvalid  out  1  one-clk read-data-valid pulse.
- aux_rdata  out  16  captured read data, held until the next capture.
- mem_read, mem_write, mem_refresh  out  1 each  memory controller command levels.
- mem_addr  out  23  command address.
- mem_din8  out  8  command write data.
- mem_dout16  in  16  memory read data.
- refresh_debt  out  4  current debt, status only.

## Operation
- phase = {vdp_dh_clk, vdp_dl_clk}. The block registers phase each clk. A slot start is the first clk on which phase differs from the registered value.
- Slot decisions are made at slot start. A decision holds for the whole slot.
- Phase 11, VDP slot:
  - mem_write = ~vdp_we_n, mem_read = vdp_we_n.
  - mem_addr = {4'b0, vdp_addr}, mem_din8 = vdp_din8.
  - The address and data track the VDP inputs for the whole slot. The aux requester is never served in this slot.
- Phase 00, refresh slot:
  - If aux pending (aux_req high, state IDLE) and debt < MAX_DEBT: grant aux. mem_read/mem_write per aux_we, mem_addr = aux_addr, mem_din8 = aux_din8, aux_ack pulses, debt +1.
  - Otherwise: mem_refresh asserted, debt −1, saturating at 0.
- Phases 01/10: no command. All mem_* command levels are 0.
- State machine:
  - IDLE → GRANT on aux grant.
  - GRANT → IDLE at slot end if aux write.
  - GRANT → RWAIT at slot end if aux read.
  - RWAIT counts READ_LAT clks, captures mem_dout16 into aux_rdata, pulses aux_rvalid, → IDLE.
  - New aux grants only occur from IDLE.
- Aux writes complete at ack. There is no further response.
- aux_req dropped before ack: no grant occurs.
- aux_req still high after ack: this is a new request and is eligible once state is IDLE.
- Debt is a 4-bit saturating counter. The grant test uses debt < MAX_DEBT, so at MAX_DEBT refresh is forced. Under continuous aux demand at MAX_DEBT, grant and refresh alternate in successive 00 slots.

## Timing
- Reset values: all outputs 0; debt 0; state IDLE; registered phase 00. A phase of 00 at reset release is not a slot start.
- Command latency: mem_* levels assert 1 clk after slot start and deassert 1 clk after the slot's last clk. There is no command gap if the next slot also issues.
- aux_ack is asserted on the same clk the aux command first appears on mem_*.
- aux_rvalid fires exactly READ_LAT clks after the aux read command's last asserted clk. aux_rdata is updated on the same clk.
- An aux_req rise on the same clk as a 00 slot start is eligible for that slot.
- Asynchronous reset mid-transaction: all mem_* commands clear immediately, the pending read is dropped (no aux_rvalid), and debt returns to 0.

## Structure
- Package vram_arb_pkg:
  - typedef enum logic [1:0] slot_e {SLOT_REFRESH=00, SLOT_IDLE_A=01, SLOT_IDLE_B=10, SLOT_VDP=11}
  - typedef enum arb_state_e {IDLE, GRANT, RWAIT}
  - localparam DEBT_W = 4
- Sub-module: refresh_debt_counter (saturating up/down counter with an at-max flag).

## Test plan
- VDP only, cycling phases 00→01→11→10, vdp_we_n=0, addr 0x12345 → mem_write high for every 11 slot with mem_addr 0x012345; mem_refresh high for every 00 slot; debt stays 0.
- Single aux read at addr 0x400000 while the memory model returns 0xBEEF → ack in the next 00 slot, no mem_refresh in that slot, aux_rvalid exactly 2 clks after the command ends, aux_rdata 0xBEEF, debt 1.
- Continuous aux writes → 8 consecutive 00 slots granted (debt reaches 8), then grant and refresh alternate with debt oscillating between 7 and 8.
- aux_req asserted during a VDP slot → no aux command in phase 11 or 01/10; grant occurs in the first subsequent 00 slot.
- reset_n asserted during RWAIT → outputs clear asynchronously, no aux_rvalid ever fires, debt 0 after release.
- aux_req rising on the 00 slot-start clk → granted in that slot, with aux_ack on the first command clk.

Source files
------------

// File: rtl/vram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : vram_arb_pkg                                               |
// | Shared types and helpers for the VRAM slot arbiter.                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package vram_arb_pkg;

  // VDP slot phase as presented on {vdp_dh_clk, vdp_dl_clk}
  typedef enum logic [1:0] {
    SLOT_REFRESH = 2'b00,
    SLOT_IDLE_A  = 2'b01,
    SLOT_IDLE_B  = 2'b10,
    SLOT_VDP     = 2'b11
  } slot_e;

  // Aux transaction progress
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    RWAIT = 2'b10
  } arb_state_e;

  localparam int DEBT_W     = 4;
  localparam int MEM_ADDR_W = 23;
  localparam int VDP_ADDR_W = 19;

  // VDP addresses live in the bottom 512K of the shared memory
  function automatic logic [MEM_ADDR_W-1:0] vdp_to_mem_addr(input logic [VDP_ADDR_W-1:0] a);
    return {{(MEM_ADDR_W-VDP_ADDR_W){1'b0}}, a};
  endfunction

endpackage
`default_nettype wire

// File: rtl/refresh_debt_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : refresh_debt_counter                                       |
// | Saturating up/down count of refresh slots lent to the aux side,      |
// | with a flag once the lending limit is reached.                       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module refresh_debt_counter
  import vram_arb_pkg::*;
#(
  parameter int WIDTH    = DEBT_W,
  parameter int MAX_DEBT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] debt,
  output logic             at_max
);

  // Count lent slots up and repaid refreshes down, clamping at both ends
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      debt <= '0;
    end else if (inc && !dec) begin
      if (debt != '1) debt <= debt + 1'b1;
    end else if (dec && !inc) begin
      if (debt != '0) debt <= debt - 1'b1;
    end
  end

  assign at_max = (debt >= WIDTH'(MAX_DEBT));

endmodule
`default_nettype wire

// File: rtl/vram_slot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vram_slot_arbiter                                          |
// | Schedules VDP and one auxiliary requester onto the SDRAM controller  |
// | by VDP slot phase; refresh slots are lent to aux under a debt bound. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module vram_slot_arbiter
  import vram_arb_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int MAX_DEBT = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vdp_dl_clk,
  input  logic                  vdp_dh_clk,
  input  logic                  vdp_we_n,
  input  logic [VDP_ADDR_W-1:0] vdp_addr,
  input  logic [7:0]            vdp_din8,
  input  logic                  aux_req,
  input  logic                  aux_we,
  input  logic [MEM_ADDR_W-1:0] aux_addr,
  input  logic [7:0]            aux_din8,
  output logic                  aux_ack,
  output logic                  aux_rvalid,
  output logic [15:0]           aux_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_refresh,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_din8,
  input  logic [15:0]           mem_dout16,
  output logic [DEBT_W-1:0]     refresh_debt
);

  // Latency counter only ever holds READ_LAT-1 down to 1
  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  slot_e             phase;
  slot_e             phase_q;
  logic              slot_start;
  arb_state_e        state;
  logic              grant_is_read;
  logic [LAT_W-1:0]  lat_cnt;
  logic              aux_pending;
  logic              at_max;
  logic              grant;
  logic              do_refresh;

  assign phase       = slot_e'({vdp_dh_clk, vdp_dl_clk});
  assign slot_start  = (phase != phase_q);
  assign aux_pending = aux_req && (state == IDLE);
  assign grant       = slot_start && (phase == SLOT_REFRESH) && aux_pending && !at_max;
  assign do_refresh  = slot_start && (phase == SLOT_REFRESH) && !grant;

  refresh_debt_counter #(
    .WIDTH    (DEBT_W),
    .MAX_DEBT (MAX_DEBT)
  ) u_debt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (grant),
    .dec     (do_refresh),
    .debt    (refresh_debt),
    .at_max  (at_max)
  );

  // Remember the previous phase so a change marks the start of a slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase_q <= SLOT_REFRESH;
    else          phase_q <= phase;
  end

  // Command levels: decided at slot start and held; a VDP slot follows its inputs every clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_refresh <= 1'b0;
      mem_addr    <= '0;
      mem_din8    <= '0;
    end else if (phase == SLOT_VDP) begin
      mem_read    <= vdp_we_n;
      mem_write   <= ~vdp_we_n;
      mem_refresh <= 1'b0;
      mem_addr    <= vdp_to_mem_addr(vdp_addr);
      mem_din8    <= vdp_din8;
    end else if (slot_start) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_refresh <= do_refresh;
      mem_addr    <= '0;
      mem_din8    <= '0;
      if (grant) begin
        mem_read  <= ~aux_we;
        mem_write <= aux_we;
        mem_addr  <= aux_addr;
        mem_din8  <= aux_din8;
      end
    end
  end

  // Aux transaction FSM: grant pulse, hold through the slot, then read-data return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      grant_is_read <= 1'b0;
      lat_cnt       <= '0;
      aux_ack       <= 1'b0;
      aux_rvalid    <= 1'b0;
      aux_rdata     <= '0;
    end else begin
      aux_ack    <= grant;
      aux_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state         <= GRANT;
            grant_is_read <= ~aux_we;
          end
        end
        GRANT: begin
          if (slot_start) begin
            if (!grant_is_read) begin
              state <= IDLE;
            end else if (READ_LAT <= 1) begin
              aux_rvalid <= 1'b1;
              aux_rdata  <= mem_dout16;
              state      <= IDLE;
            end else begin
              lat_cnt <= LAT_W'(READ_LAT - 1);
              state   <= RWAIT;
            end
          end
        end
        RWAIT: begin
          if (lat_cnt == LAT_W'(1)) begin
            aux_rvalid <= 1'b1;
            aux_rdata  <= mem_dout16;
            state      <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_slot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_vram_slot_arbiter                                       |
// | Self-checking bench for vram_slot_arbiter against a slot-level model.|
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_vram_slot_arbiter;

  localparam int READ_LAT = 2;
  localparam int MAX_DEBT = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vdp_dl_clk = 1'b0, vdp_dh_clk = 1'b0, vdp_we_n = 1'b1;
  logic [18:0] vdp_addr = '0;
  logic [7:0]  vdp_din8 = '0;
  logic        aux_req = 1'b0, aux_we = 1'b0;
  logic [22:0] aux_addr = '0;
  logic [7:0]  aux_din8 = '0;
  logic [15:0] mem_dout16 = '0;
  logic        aux_ack, aux_rvalid, mem_read, mem_write, mem_refresh;
  logic [15:0] aux_rdata;
  logic [22:0] mem_addr;
  logic [7:0]  mem_din8;
  logic [3:0]  refresh_debt;

  int n_cmp = 0;
  int n_bad = 0;

  vram_slot_arbiter #(.READ_LAT(READ_LAT), .MAX_DEBT(MAX_DEBT)) dut (
    .clk(clk), .reset_n(reset_n),
    .vdp_dl_clk(vdp_dl_clk), .vdp_dh_clk(vdp_dh_clk), .vdp_we_n(vdp_we_n),
    .vdp_addr(vdp_addr), .vdp_din8(vdp_din8),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_din8(aux_din8),
    .aux_ack(aux_ack), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
    .mem_addr(mem_addr), .mem_din8(mem_din8), .mem_dout16(mem_dout16),
    .refresh_debt(refresh_debt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (slot-level, one call per clock edge) ----
  int          m_cyc = 0;
  logic [1:0]  m_phase = 2'b00;
  logic [3:0]  m_debt = '0;
  bit          m_granted = 0, m_gr_we = 0, m_due_valid = 0;
  int          m_due = 0;
  logic        e_read = 0, e_write = 0, e_refresh = 0, e_ack = 0, e_rvalid = 0;
  logic [22:0] e_addr = '0;
  logic [7:0]  e_din = '0;
  logic [15:0] e_rdata = '0;

  wire [55:0] dut_bus = {mem_read, mem_write, mem_refresh, mem_addr, mem_din8,
                         aux_ack, aux_rvalid, aux_rdata, refresh_debt};
  wire [55:0] exp_bus = {e_read, e_write, e_refresh, e_addr, e_din,
                         e_ack, e_rvalid, e_rdata, m_debt};

  task automatic model_reset();
    m_phase = 2'b00; m_debt = '0; m_granted = 0; m_gr_we = 0; m_due_valid = 0;
    e_read = 0; e_write = 0; e_refresh = 0; e_ack = 0; e_rvalid = 0;
    e_addr = '0; e_din = '0; e_rdata = '0;
  endtask

  task automatic model_edge();
    logic [1:0] p;
    bit start, busy;
    p     = {vdp_dh_clk, vdp_dl_clk};
    start = (p != m_phase);
    busy  = m_granted || m_due_valid;
    e_ack = 0; e_rvalid = 0;
    // The granted slot ends here; a read's last command clk was the previous one
    if (start && m_granted) begin
      m_granted = 0;
      if (!m_gr_we) begin
        m_due = m_cyc - 1 + READ_LAT;
        m_due_valid = 1;
      end
    end
    if (m_due_valid && m_cyc == m_due) begin
      e_rvalid = 1; e_rdata = mem_dout16; m_due_valid = 0;
    end
    if (start) begin
      e_read = 0; e_write = 0; e_refresh = 0; e_addr = '0; e_din = '0;
      if (p == 2'b00) begin
        if (aux_req && !busy && (int'(m_debt) < MAX_DEBT)) begin
          e_read = !aux_we; e_write = aux_we; e_addr = aux_addr; e_din = aux_din8;
          e_ack = 1; m_debt = m_debt + 1; m_granted = 1; m_gr_we = aux_we;
        end else begin
          e_refresh = 1;
          if (m_debt != 0) m_debt = m_debt - 1;
        end
      end
    end
    // A VDP slot follows the VDP inputs for its whole length
    if (p == 2'b11) begin
      e_read = vdp_we_n; e_write = !vdp_we_n; e_addr = {4'b0, vdp_addr}; e_din = vdp_din8;
    end
    m_phase = p;
    m_cyc++;
  endtask

  // One clock: DUT and model both take the edge, then we return at the negedge
  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge(); else model_reset();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; aux_req = 1'b0; {vdp_dh_clk, vdp_dl_clk} = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Canonical phase order 01 -> 11 -> 10 -> 00 with fixed slot length
  function automatic logic [1:0] canon(input int c, input int len);
    case ((c / len) % 4)
      0:       return 2'b01;
      1:       return 2'b11;
      2:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; aux_req = 1'b0; {vdp_dh_clk, vdp_dl_clk} = 2'b00;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dut_bus !== 56'd0) begin
      n_bad++; $display("FAIL reset_outputs got=%h exp=0", dut_bus);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (dut_bus !== 56'd0 || dut_bus !== exp_bus) begin
        n_bad++; $display("FAIL reset_no_slot_start c=%0d got=%h exp=0", c, dut_bus);
      end
    end
  endtask

  task automatic test_vdp_only();
    logic [1:0] p;
    do_reset();
    vdp_we_n = 1'b0; vdp_addr = 19'h12345; vdp_din8 = 8'h6C;
    for (int c = 0; c < 32; c++) begin
      p = canon(c, 2);
      {vdp_dh_clk, vdp_dl_clk} = p;
      step();
      n_cmp++;
      if (dut_bus !== exp_bus) begin
        n_bad++; $display("FAIL vdp_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus);
      end
      if (p == 2'b11) begin
        n_cmp++;
        if (!(mem_write === 1'b1 && mem_read === 1'b0 && mem_addr === 23'h012345)) begin
          n_bad++; $display("FAIL vdp_write c=%0d got w=%b a=%h exp w=1 a=012345", c, mem_write, mem_addr);
        end
      end
      if (p == 2'b00) begin
        n_cmp++;
        if (mem_refresh !== 1'b1) begin
          n_bad++; $display("FAIL vdp_refresh c=%0d got=%b exp=1", c, mem_refresh);
        end
      end
      n_cmp++;
      if (refresh_debt !== 4'd0) begin
        n_bad++; $display("FAIL vdp_debt c=%0d got=%0d exp=0", c, refresh_debt);
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 23'h400000; aux_din8 = 8'h00;
    mem_dout16 = 16'hBEEF;
    for (int c = 0; c < 16; c++) begin
      {vdp_dh_clk, vdp_dl_clk} = canon(c, 2);
      vdp_we_n = 1'($urandom_range(1));
      step();
      n_cmp++;
      if (dut_bus !== exp_bus) begin
        n_bad++; $display("FAIL read_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus);
      end
      n_cmp++;
      if (aux_ack !== (c == 6) || aux_rvalid !== (c == 9)) begin
        n_bad++; $display("FAIL read_timing c=%0d got ack=%b rv=%b exp ack=%b rv=%b", c, aux_ack, aux_rvalid, c == 6, c == 9);
      end
      if (c == 6 || c == 7) begin
        n_cmp++;
        if (!(mem_read === 1'b1 && mem_refresh === 1'b0 && mem_addr === 23'h400000)) begin
          n_bad++; $display("FAIL read_cmd c=%0d got rd=%b rf=%b a=%h exp rd=1 rf=0 a=400000", c, mem_read, mem_refresh, mem_addr);
        end
      end
      if (c == 9) begin
        n_cmp++;
        if (aux_rdata !== 16'hBEEF || refresh_debt !== 4'd1) begin
          n_bad++; $display("FAIL read_data got=%h debt=%0d exp=BEEF debt=1", aux_rdata, refresh_debt);
        end
      end
      if (e_ack) aux_req = 1'b0;
    end
  endtask

  task automatic test_continuous_writes();
    int  k;
    bit  g;
    int  d;
    do_reset();
    aux_req = 1'b1; aux_we = 1'b1; aux_addr = 23'h155AA0; aux_din8 = 8'h3C;
    for (int c = 0; c < 60; c++) begin
      {vdp_dh_clk, vdp_dl_clk} = canon(c, 1);
      vdp_we_n = 1'($urandom_range(1));
      step();
      n_cmp++;
      if (dut_bus !== exp_bus) begin
        n_bad++; $display("FAIL cont_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus);
      end
      if (c % 4 == 3) begin
        k = c / 4;
        g = (k < MAX_DEBT) || (((k - MAX_DEBT) % 2) == 1);
        d = (k < MAX_DEBT) ? k + 1 : ((((k - MAX_DEBT) % 2) == 0) ? MAX_DEBT - 1 : MAX_DEBT);
        n_cmp++;
        if (aux_ack !== g || mem_write !== g || mem_refresh !== !g || int'(refresh_debt) != d) begin
          n_bad++; $display("FAIL cont_slot k=%0d got ack=%b wr=%b rf=%b debt=%0d exp ack=%b debt=%0d", k, aux_ack, mem_write, mem_refresh, refresh_debt, g, d);
        end
      end
    end
    aux_req = 1'b0;
  endtask

  task automatic test_req_in_vdp_slot();
    do_reset();
    vdp_we_n = 1'b1; vdp_addr = 19'h0F0F0; vdp_din8 = 8'h11;
    for (int c = 0; c < 16; c++) begin
      {vdp_dh_clk, vdp_dl_clk} = canon(c, 2);
      if (c == 2) begin
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 23'h7ABCDE; aux_din8 = 8'h5A;
      end
      step();
      n_cmp++;
      if (dut_bus !== exp_bus) begin
        n_bad++; $display("FAIL vdpreq_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus);
      end
      if (c == 2 || c == 3) begin
        n_cmp++;
        if (!(mem_read === 1'b1 && mem_addr === 23'h00F0F0 && aux_ack === 1'b0)) begin
          n_bad++; $display("FAIL vdpreq_vdp c=%0d got rd=%b a=%h ack=%b exp rd=1 a=00F0F0 ack=0", c, mem_read, mem_addr, aux_ack);
        end
      end
      if (c == 4 || c == 5) begin
        n_cmp++;
        if ({mem_read, mem_write, mem_refresh, aux_ack} !== 4'b0) begin
          n_bad++; $display("FAIL vdpreq_idle c=%0d got=%b exp=0000", c, {mem_read, mem_write, mem_refresh, aux_ack});
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (!(aux_ack === 1'b1 && mem_write === 1'b1 && mem_addr === 23'h7ABCDE && mem_din8 === 8'h5A)) begin
          n_bad++; $display("FAIL vdpreq_grant got ack=%b wr=%b a=%h d=%h exp ack=1 wr=1 a=7ABCDE d=5A", aux_ack, mem_write, mem_addr, mem_din8);
        end
      end
      if (e_ack) aux_req = 1'b0;
    end
  endtask

  task automatic test_reset_rwait();
    bit rv_seen;
    do_reset();
    aux_req = 1'b1; aux_we = 1'b0; aux_addr = 23'h123456; mem_dout16 = 16'hA5C3;
    for (int c = 0; c <= 8; c++) begin
      {vdp_dh_clk, vdp_dl_clk} = canon(c, 2);
      step();
      n_cmp++;
      if (dut_bus !== exp_bus) begin
        n_bad++; $display("FAIL rwait_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus);
      end
      if (e_ack) aux_req = 1'b0;
    end
    // Read is now waiting for data; pull reset between edges
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dut_bus !== 56'd0) begin
      n_bad++; $display("FAIL rwait_async_clear got=%h exp=0", dut_bus);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    rv_seen = 0;
    for (int c = 9; c < 25; c++) begin
      {vdp_dh_clk, vdp_dl_clk} = canon(c, 2);
      step();
      if (aux_rvalid === 1'b1) rv_seen = 1;
      n_cmp++;
      if (dut_bus !== exp_bus) begin
        n_bad++; $display("FAIL rwait_after_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus);
      end
      if (c == 9) begin
        n_cmp++;
        if (refresh_debt !== 4'd0) begin
          n_bad++; $display("FAIL rwait_debt got=%0d exp=0", refresh_debt);
        end
      end
    end
    n_cmp++;
    if (rv_seen) begin
      n_bad++; $display("FAIL rwait_dropped got rvalid=1 exp none");
    end
  endtask

  task automatic test_same_clk_rise();
    do_reset();
    mem_dout16 = 16'h1D2E;
    for (int c = 0; c < 12; c++) begin
      {vdp_dh_clk, vdp_dl_clk} = canon(c, 2);
      if (c == 6) begin
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 23'h0ABCDE;
      end
      step();
      n_cmp++;
      if (dut_bus !== exp_bus) begin
        n_bad++; $display("FAIL rise_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus);
      end
      n_cmp++;
      if (aux_ack !== (c == 6)) begin
        n_bad++; $display("FAIL rise_ack c=%0d got=%b exp=%b", c, aux_ack, c == 6);
      end
      if (c == 6) begin
        n_cmp++;
        if (!(mem_read === 1'b1 && mem_refresh === 1'b0 && mem_addr === 23'h0ABCDE)) begin
          n_bad++; $display("FAIL rise_cmd got rd=%b rf=%b a=%h exp rd=1 rf=0 a=0ABCDE", mem_read, mem_refresh, mem_addr);
        end
      end
      if (e_ack) aux_req = 1'b0;
    end
  endtask

  task automatic test_random();
    logic [1:0] ph;
    int len_left;
    do_reset();
    ph = 2'b00; len_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (len_left == 0) begin
        if ($urandom_range(3) == 0) ph = 2'($urandom);
        else ph = canon(int'(ph == 2'b00) * 0 + ((ph == 2'b01) ? 1 : (ph == 2'b11) ? 2 : (ph == 2'b10) ? 3 : 0), 1);
        len_left = $urandom_range(3, 1);
      end
      len_left--;
      {vdp_dh_clk, vdp_dl_clk} = ph;
      vdp_we_n   = 1'($urandom_range(1));
      vdp_addr   = 19'($urandom);
      vdp_din8   = 8'($urandom);
      mem_dout16 = 16'($urandom);
      step();
      n_cmp++;
      if (dut_bus !== exp_bus) begin
        n_bad++; $display("FAIL random_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus);
      end
      // Requester: holds until ack, sometimes gives up, sometimes re-requests at once
      if (aux_req) begin
        if (e_ack) begin
          if ($urandom_range(3) != 0) aux_req = 1'b0;
        end else if ($urandom_range(49) == 0) begin
          aux_req = 1'b0;
        end
      end else if ($urandom_range(3) == 0) begin
        aux_req  = 1'b1;
        aux_we   = 1'($urandom_range(1));
        aux_addr = 23'($urandom);
        aux_din8 = 8'($urandom);
      end
    end
    aux_req = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_vdp_only();
    test_single_read();
    test_continuous_writes();
    test_req_in_vdp_slot();
    test_reset_rwait();
    test_same_clk_rise();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
